// File: rtl/regfile_writer_pkg.sv
// -----------------------------------------------------------------------------
// regfile_writer_pkg
// Shared definitions for the register-file write sequencer.
//   REG_IDX_W  : register index width of the 32x32 register file
//   REG_DATA_W : register data width
//   REG_ZERO   : index of the hard-wired zero register ($0)
//   wb_entry_t : one write-back result {index, data}
// -----------------------------------------------------------------------------
package regfile_writer_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic [REG_IDX_W-1:0]  index;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writer_match.sv
// -----------------------------------------------------------------------------
// regfile_writer_match
// Combinational scan of the write queue and write stage for one read index.
// Optional feature macro: REGFILE_WRITER_FWD_EN (adds forwarded data path).
// Ports:
//   q_index   in   read index being looked up
//   ent_index in   queue storage, index field per slot
//   head      in   oldest valid slot
//   count     in   number of valid slots
//   wr_en     in   write stage holds a valid write
//   wr_index  in   write stage index
//   ent_data  in   queue storage, data field per slot      (FWD_EN only)
//   wr_data   in   write stage data                        (FWD_EN only)
//   data      out  youngest matching value, 0 when no hit  (FWD_EN only)
//   hit       out  a write to q_index is queued or in flight
// -----------------------------------------------------------------------------
module regfile_writer_match
    import regfile_writer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int IDX_W  = REG_IDX_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic [IDX_W-1:0]          q_index,
    input  logic [IDX_W-1:0]          ent_index [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]  head,
    input  logic [$clog2(DEPTH):0]    count,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_index,
`ifdef REGFILE_WRITER_FWD_EN
    input  logic [DATA_W-1:0]         ent_data [DEPTH],
    input  logic [DATA_W-1:0]         wr_data,
    output logic [DATA_W-1:0]         data,
`endif
    output logic                      hit
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] slot;

`ifdef REGFILE_WRITER_FWD_EN
    // Walk from the write stage (oldest) through head..tail-1 (youngest);
    // later matches overwrite earlier ones, so the youngest value wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        slot = '0;
        if (wr_en && (wr_index == q_index)) begin
            hit  = 1'b1;
            data = wr_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (ent_index[slot] == q_index)) begin
                hit  = 1'b1;
                data = ent_data[slot];
            end
        end
        // $0 always reads as zero, so it is never considered pending.
        if (q_index == IDX_W'(REG_ZERO)) begin
            hit  = 1'b0;
            data = '0;
        end
    end
`else
    always_comb begin
        hit  = wr_en && (wr_index == q_index);
        slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (ent_index[slot] == q_index)) begin
                hit = 1'b1;
            end
        end
        if (q_index == IDX_W'(REG_ZERO)) begin
            hit = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/regfile_writer.sv
// -----------------------------------------------------------------------------
// regfile_writer
// Write-side sequencer for the 32x32 register file. Producers push
// {index, data} results into an in-order circular queue; one entry per cycle
// drains into a registered write stage that drives the register-file write
// port. Pending flags (and optionally forwarded data) are published for the
// two register-file read indices.
// Optional feature macro: REGFILE_WRITER_FWD_EN (fwd_data_k carries the
// youngest pending value; otherwise fwd_data_k is tied to 0).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    producer handshake (in_ready combinational)
//   in_index/in_data     destination register and result value
//   wr_en/wr_index/wr_data  registered register-file write port
//   q_index_1/q_index_2  mirrors of the register-file read indices
//   pend_1/pend_2        write to that index queued or in flight
//   fwd_data_1/_2        youngest pending value for that index
//   empty                queue and write stage both idle
// -----------------------------------------------------------------------------
module regfile_writer
    import regfile_writer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int IDX_W  = REG_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [DATA_W-1:0] in_data,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_index,
    output logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  q_index_1,
    input  logic [IDX_W-1:0]  q_index_2,
    output logic              pend_1,
    output logic              pend_2,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [IDX_W-1:0]  mem_index_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q  [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [IDX_W-1:0]  wr_index_q, wr_index_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic push_hs;
    logic push;
    logic pop;

    // Full is judged on the current count only; a same-cycle pop does not
    // open a slot for the producer.
    assign in_ready = !rst && (count_q < FULL_CNT);
    assign push_hs  = in_valid && in_ready;
    // Writes to $0 complete the handshake but are dropped here.
    assign push     = push_hs && (in_index != IDX_W'(REG_ZERO));
    assign pop      = (count_q != '0);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        wr_index_d = wr_index_q;
        wr_data_d  = wr_data_q;
        if (pop) begin
            wr_en_d    = 1'b1;
            wr_index_d = mem_index_q[head_q];
            wr_data_d  = mem_data_q[head_q];
            head_d     = head_q + PTR_W'(1);
        end
        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            wr_index_q <= wr_index_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // NOTE: storage is deliberately not reset; a slot is only ever read
    // while count marks it valid, so clearing pointers and count suffices.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_index_q[tail_q] <= in_index;
            mem_data_q[tail_q]  <= in_data;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_index = wr_index_q;
    assign wr_data  = wr_data_q;
    assign empty    = (count_q == '0) && !wr_en_q;

    regfile_writer_match #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_match_1 (
        .q_index   (q_index_1),
        .ent_index (mem_index_q),
        .head      (head_q),
        .count     (count_q),
        .wr_en     (wr_en_q),
        .wr_index  (wr_index_q),
`ifdef REGFILE_WRITER_FWD_EN
        .ent_data  (mem_data_q),
        .wr_data   (wr_data_q),
        .data      (fwd_data_1),
`endif
        .hit       (pend_1)
    );

    regfile_writer_match #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_match_2 (
        .q_index   (q_index_2),
        .ent_index (mem_index_q),
        .head      (head_q),
        .count     (count_q),
        .wr_en     (wr_en_q),
        .wr_index  (wr_index_q),
`ifdef REGFILE_WRITER_FWD_EN
        .ent_data  (mem_data_q),
        .wr_data   (wr_data_q),
        .data      (fwd_data_2),
`endif
        .hit       (pend_2)
    );

`ifndef REGFILE_WRITER_FWD_EN
    assign fwd_data_1 = '0;
    assign fwd_data_2 = '0;
`endif

endmodule

// File: tb/tb_regfile_writer.sv
// -----------------------------------------------------------------------------
// tb_regfile_writer
// Self-checking bench for regfile_writer. A queue-based reference model tracks
// the pending results and the write stage; every cycle all outputs are
// compared against it. Directed scenarios come first, then random traffic.
// -----------------------------------------------------------------------------
module tb_regfile_writer;
    import regfile_writer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_index;
    logic [31:0] in_data;
    logic        wr_en;
    logic [4:0]  wr_index;
    logic [31:0] wr_data;
    logic [4:0]  q_index_1;
    logic [4:0]  q_index_2;
    logic        pend_1;
    logic        pend_2;
    logic [31:0] fwd_data_1;
    logic [31:0] fwd_data_2;
    logic        empty;

    always #5 clk = ~clk;

    regfile_writer #(.DEPTH(DEPTH), .DATA_W(32), .IDX_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_index   (in_index),
        .in_data    (in_data),
        .wr_en      (wr_en),
        .wr_index   (wr_index),
        .wr_data    (wr_data),
        .q_index_1  (q_index_1),
        .q_index_2  (q_index_2),
        .pend_1     (pend_1),
        .pend_2     (pend_2),
        .fwd_data_1 (fwd_data_1),
        .fwd_data_2 (fwd_data_2),
        .empty      (empty)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: results waiting in order, plus the write stage.
    wb_entry_t   mq[$];
    logic        m_wr_en;
    logic [4:0]  m_wr_idx;
    logic [31:0] m_wr_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_pend(input logic [4:0] qi);
        if (qi == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].index == qi) return 1'b1;
        return m_wr_en && (m_wr_idx == qi);
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] qi);
`ifdef REGFILE_WRITER_FWD_EN
        if (qi == 5'd0) return 32'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].index == qi) return mq[i].data;
        if (m_wr_en && (m_wr_idx == qi)) return m_wr_data;
        return 32'd0;
`else
        return (qi == 5'd0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // One clock cycle: drive inputs, compare every output, then advance model.
    task automatic step(input logic v, input logic [4:0] idx, input logic [31:0] d,
                        input logic [4:0] q1, input logic [4:0] q2, input logic r,
                        output logic acc);
        logic      exp_ready;
        wb_entry_t e;
        @(negedge clk);
        in_valid  = v;
        in_index  = idx;
        in_data   = d;
        q_index_1 = q1;
        q_index_2 = q2;
        rst       = r;
        #1;
        exp_ready = !r && (mq.size() < DEPTH);
        check("in_ready",   32'(in_ready),   32'(exp_ready));
        check("wr_en",      32'(wr_en),      32'(m_wr_en));
        check("wr_index",   32'(wr_index),   32'(m_wr_idx));
        check("wr_data",    wr_data,         m_wr_data);
        check("pend_1",     32'(pend_1),     32'(m_pend(q1)));
        check("pend_2",     32'(pend_2),     32'(m_pend(q2)));
        check("fwd_data_1", fwd_data_1,      m_fwd(q1));
        check("fwd_data_2", fwd_data_2,      m_fwd(q2));
        check("empty",      32'(empty),      32'((mq.size() == 0) && !m_wr_en));
        acc = v && exp_ready;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_wr_en   = 1'b0;
            m_wr_idx  = '0;
            m_wr_data = '0;
        end else begin
            if (mq.size() > 0) begin
                e         = mq.pop_front();
                m_wr_en   = 1'b1;
                m_wr_idx  = e.index;
                m_wr_data = e.data;
            end else begin
                m_wr_en = 1'b0;
            end
            if (acc && (idx != 5'd0)) mq.push_back('{index: idx, data: d});
        end
    endtask

    initial begin
        logic acc;
        logic [4:0] i;
        in_valid  = 1'b0;
        in_index  = '0;
        in_data   = '0;
        q_index_1 = '0;
        q_index_2 = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        m_wr_en   = 1'b0;
        m_wr_idx  = '0;
        m_wr_data = '0;

        // Reset state, still holding rst, then release.
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b1, acc);
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, acc);

        // Single write: visible on the write port two cycles later, once.
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, acc);
        check("single_accept", 32'(acc), 32'd1);
        repeat (4) step(1'b0, 5'd0, 32'd0, 5'd5, 5'd3, 1'b0, acc);

        // Back-to-back indices 1..6, each held until accepted.
        i = 5'd1;
        while (i <= 5'd6) begin
            step(1'b1, i, 32'hA000_0000 | 32'(i), i, 5'd6, 1'b0, acc);
            if (acc) i = i + 5'd1;
        end
        repeat (4) step(1'b0, 5'd0, 32'd0, 5'd4, 5'd6, 1'b0, acc);

        // $0 discard: handshake completes, nothing is written for it.
        step(1'b1, 5'd0, 32'h1234, 5'd0, 5'd3, 1'b0, acc);
        check("zero_accept", 32'(acc), 32'd1);
        step(1'b1, 5'd3, 32'h55, 5'd0, 5'd3, 1'b0, acc);
        repeat (3) step(1'b0, 5'd0, 32'd0, 5'd0, 5'd3, 1'b0, acc);

        // Two writes to the same index: pending and youngest-value forward.
        step(1'b1, 5'd7, 32'h11, 5'd7, 5'd7, 1'b0, acc);
        step(1'b1, 5'd7, 32'h22, 5'd7, 5'd7, 1'b0, acc);
        repeat (4) step(1'b0, 5'd0, 32'd0, 5'd7, 5'd2, 1'b0, acc);

        // Reset mid-operation discards queued work.
        step(1'b1, 5'd9,  32'h99, 5'd9, 5'd10, 1'b0, acc);
        step(1'b1, 5'd10, 32'hAA, 5'd9, 5'd10, 1'b0, acc);
        step(1'b1, 5'd11, 32'hBB, 5'd9, 5'd11, 1'b1, acc);
        check("rst_no_accept", 32'(acc), 32'd0);
        repeat (3) step(1'b0, 5'd0, 32'd0, 5'd9, 5'd11, 1'b0, acc);

        // Random traffic over a narrow index range to provoke matches.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)),
                 $urandom,
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 49) == 0),
                 acc);
        end
        repeat (4) step(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
